// File: rtl/pshifter_pipe.sv
// Pipelined barrel shifter: one stage per shift-amount bit, logical/arithmetic/rotate,
// valid/ready handshake with a stall-the-whole-pipe backpressure scheme.
module pshifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    shiftby,
  input  logic             shiftdir,
  input  logic             shifta,
  input  logic             rotate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
);

  if (WIDTH < 8 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pshifter_pipe: WIDTH must be a power of two in 8..128");
  end

  // Stage k registers; side-band is only needed by stages that still have work to do.
  logic [WIDTH-1:0] r_data [SW];
  logic [SW-1:0]    r_valid;
  logic [SW-2:0]    r_dir;
  logic [SW-2:0]    r_sha;
  logic [SW-2:0]    r_rot;
  logic [SW-2:0]    r_fill;
  logic [SW-1:0]    r_sb   [SW-1];

  // Inputs seen by stage k (stage 0 from the ports, the rest from stage k-1).
  logic [WIDTH-1:0] w_d    [SW];
  logic [WIDTH-1:0] w_res  [SW];
  logic [SW-1:0]    w_sb   [SW];
  logic [SW-1:0]    w_v;
  logic [SW-1:0]    w_dir;
  logic [SW-1:0]    w_sha;
  logic [SW-1:0]    w_rot;
  logic [SW-1:0]    w_fill;
  logic             w_adv;

  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input int               amt,
    input logic             dir,
    input logic             rot,
    input logic             fill
  );
    logic [WIDTH-1:0] mask;
    mask = ~({WIDTH{1'b1}} >> amt);
    if (amt == 0)
      stage_shift = d;
    else if (dir)
      stage_shift = rot ? ((d << amt) | (d >> (WIDTH - amt))) : (d << amt);
    else if (rot)
      stage_shift = (d >> amt) | (d << (WIDTH - amt));
    else
      stage_shift = (d >> amt) | (fill ? mask : '0);
  endfunction

  // NOTE: every element is written unconditionally, so no latch can be inferred.
  always_comb begin
    w_d[0]    = in;
    w_v[0]    = in_valid;
    w_dir[0]  = shiftdir;
    w_sha[0]  = shifta;
    w_rot[0]  = rotate;
    w_fill[0] = in[WIDTH-1];
    w_sb[0]   = shiftby;
    for (int k = 1; k < SW; k++) begin
      w_d[k]    = r_data[k-1];
      w_v[k]    = r_valid[k-1];
      w_dir[k]  = r_dir[k-1];
      w_sha[k]  = r_sha[k-1];
      w_rot[k]  = r_rot[k-1];
      w_fill[k] = r_fill[k-1];
      w_sb[k]   = r_sb[k-1];
    end
  end

  // Sign fill applies only to an arithmetic right shift; rotate and left ignore shifta.
  always_comb begin
    for (int k = 0; k < SW; k++) begin
      w_res[k] = stage_shift(w_d[k], w_sb[k][k] ? (1 << k) : 0, w_dir[k], w_rot[k],
                             w_fill[k] & w_sha[k] & ~w_dir[k] & ~w_rot[k]);
    end
  end

  assign in_ready = rst | ~r_valid[SW-1] | out_ready;
  assign w_adv    = in_ready;

  // NOTE: side-band bits are qualified by valid, so only valid and data need reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < SW; k++) r_data[k] <= '0;
    end else if (w_adv) begin
      r_valid <= w_v;
      for (int k = 0; k < SW; k++) r_data[k] <= w_res[k];
      for (int k = 0; k < SW - 1; k++) begin
        r_dir[k]  <= w_dir[k];
        r_sha[k]  <= w_sha[k];
        r_rot[k]  <= w_rot[k];
        r_fill[k] <= w_fill[k];
        r_sb[k]   <= w_sb[k];
      end
    end
  end

  assign out_valid = r_valid[SW-1];
  assign out       = r_data[SW-1];
  assign out_zero  = r_valid[SW-1] & ~|r_data[SW-1];

endmodule

// File: tb/tb_pshifter_pipe.sv
// Scoreboard bench for pshifter_pipe (WIDTH=32): bit-serial reference model,
// directed shift vectors, back-to-back, backpressure, mid-flight reset, random traffic.
module tb_pshifter_pipe;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] shiftby;
  logic          shiftdir;
  logic          shifta;
  logic          rotate;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
  } exp_t;
  exp_t exp_q [$];

  pshifter_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_data),
    .shiftby(shiftby), .shiftdir(shiftdir), .shifta(shifta), .rotate(rotate),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_data), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // One bit position per iteration, independent of the DUT's power-of-two stages.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [SW-1:0] sb,
                                         input logic dir, input logic sha, input logic rot);
    logic [W-1:0] d;
    d = a;
    for (int i = 0; i < int'(sb); i++) begin
      if (dir) d = rot ? {d[W-2:0], d[W-1]} : {d[W-2:0], 1'b0};
      else     d = rot ? {d[0], d[W-1:1]} : {(sha & a[W-1]), d[W-1:1]};
    end
    return d;
  endfunction

  // Scoreboard: push on acceptance, pop on output transfer; reset flushes in-flight work.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: unexpected result out=%h", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_zero !== e.zero) begin
            errors++;
            $display("FAIL sb_data: out=%h zero=%b expected out=%h zero=%b",
                     out_data, out_zero, e.data, e.zero);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.data = model(in_data, shiftby, shiftdir, shifta, rotate);
        e.zero = (e.data == '0);
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [SW-1:0] sb,
                       input logic dir, input logic sha, input logic rot);
    in_valid = v; in_data = a; shiftby = sb; shiftdir = dir; shifta = sha; rotate = rot;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d results outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: valid=%b out=%h zero=%b in_ready=%b required 0/0/0/1",
                 out_valid, out_data, out_zero, in_ready);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  // Single request from an idle pipe: checks latency, value and zero flag directly.
  task automatic run_one(input string name, input logic [W-1:0] a, input logic [SW-1:0] sb,
                         input logic dir, input logic sha, input logic rot,
                         input logic [W-1:0] expv);
    int lat = 0;
    out_ready = 1'b1;
    drive(1'b1, a, sb, dir, sha, rot);
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    checks++;
    if (lat != SW) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, SW);
    end
    checks++;
    if (out_data !== expv || out_zero !== (expv == '0)) begin
      errors++;
      $display("FAIL %s_value: out=%h zero=%b, required out=%h zero=%b",
               name, out_data, out_zero, expv, (expv == '0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_left();
    run_one("left_logical", 32'h9800_0009, 5'd4, 1'b1, 1'b0, 1'b0, 32'h8000_0090);
    run_one("left_shifta", 32'h9800_0009, 5'd4, 1'b1, 1'b1, 1'b0, 32'h8000_0090);
  endtask

  task automatic test_right();
    run_one("right_logical", 32'h9000_0009, 5'd3, 1'b0, 1'b0, 1'b0, 32'h1200_0001);
    run_one("right_arith_neg", 32'h9000_0009, 5'd3, 1'b0, 1'b1, 1'b0, 32'hF200_0001);
    run_one("right_arith_pos", 32'h1000_0009, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0200_0001);
    run_one("right_arith_31", 32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
  endtask

  task automatic test_rotate();
    run_one("rotl4", 32'h9800_0009, 5'd4, 1'b1, 1'b0, 1'b1, 32'h8000_0099);
    run_one("rotr3", 32'h9000_0009, 5'd3, 1'b0, 1'b1, 1'b1, 32'h3200_0001);
    run_one("rotr31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
  endtask

  task automatic test_shift_zero();
    for (int m = 0; m < 6; m++) begin
      logic [2:0] mode;
      mode = 3'(m);
      run_one("shift0", 32'hA5C3_0F81, 5'd0, mode[0], mode[1], mode[2], 32'hA5C3_0F81);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 0)      drive(1'b1, 32'h0000_0001, 5'd0, 1'b1, 1'b0, 1'b0);
      else if (c == 1) drive(1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 1'b0);
      else if (c < 8)  drive(1'b1, $urandom, 5'($urandom_range(0, 31)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
      else             in_valid = 1'b0;
      @(posedge clk); #1;
      exp_v = (c + 1 >= SW) && (c + 1 <= SW + 7);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid: edge %0d out_valid=%b, required %b", c + 1, out_valid, exp_v);
      end
      if (c + 1 == SW || c + 1 == SW + 1) begin
        checks++;
        if (out_zero !== (c + 1 == SW + 1)) begin
          errors++;
          $display("FAIL b2b_zero: edge %0d out_zero=%b, required %b",
                   c + 1, out_zero, (c + 1 == SW + 1));
        end
      end
    end
    wait_drain("b2b", 20);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < SW; i++) begin
      drive(1'b1, $urandom, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b0);
    held = out_data;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held || exp_q.size() != SW) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b valid=%b out=%h queued=%0d, required 0/1/%h/%0d",
                 in_ready, out_valid, out_data, exp_q.size(), held, SW);
      end
    end
    wait_drain("bp", 20);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1234_5678 + i, 5'(i + 1), 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive(1'b1, 32'hFFFF_0000, 5'd2, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: in_ready=%b during reset, required 1", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < SW + 2; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_flush: cycle %0d out_valid=%b in_ready=%b, required 0/1",
                 i, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    run_one("post_reset", 32'h0000_00F0, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0000_000F);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    wait_drain("random", 40);
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_rotate();
    test_shift_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pshifter_pipe.md
PSHIFTER_PIPE -- requirements
Module: pshifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..128.
REQ-002 SHALL have derived localparam SW = log2(WIDTH), shift-amount width and pipeline depth.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-007 SHALL have port in  input  WIDTH  operand.
REQ-008 SHALL have port shiftby  input  SW  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port shiftdir  input  1  1 = left, 0 = right.
REQ-010 SHALL have port shifta  input  1  arithmetic right; ignored for left and rotate.
REQ-011 SHALL have port rotate  input  1  rotate in shiftdir direction; overrides shifta.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result when out_valid && out_ready.
REQ-014 SHALL have port out  output  WIDTH  result.
REQ-015 SHALL have port out_zero  output  1  out == 0, qualified by out_valid.

Function
REQ-016 SHALL implement SW pipeline stages; stage k applies a shift of 2^k when shiftby[k]=1, else passes data through, then registers the data.
REQ-017 SHALL carry valid, shiftdir, shifta, rotate, remaining shiftby bits and the fill bit alongside data in every stage.
REQ-018 SHALL fill vacated bits with 0 for logical shifts, with in[WIDTH-1] (captured at acceptance) for arithmetic right, and with wrapped-out bits for rotate.
REQ-019 SHALL treat left with shifta=1 and rotate=0 as a logical left shift.
REQ-020 SHALL produce out_valid exactly SW cycles after acceptance when out_ready is held high; for WIDTH=32 this is 5 cycles.
REQ-021 SHALL sustain one accepted request per cycle when out_ready is high.
REQ-022 SHALL drive in_ready = !out_valid || out_ready (combinational); the whole pipeline advances only when in_ready=1.
REQ-023 SHALL freeze all stage registers, out and out_valid while in_ready=0; bubbles are not collapsed.
REQ-024 SHALL insert a bubble (valid=0) into stage 0 on an advancing cycle without acceptance.
REQ-025 SHALL hold out stable while out_valid=1 and out_ready=0.
REQ-026 SHALL return in unchanged for shiftby=0 in every mode.
REQ-027 SHALL deliver results in acceptance order; no reordering, no drops, no duplicates.
REQ-028 SHALL compute out_zero from the registered final-stage data.

Reset
REQ-029 SHALL on rst=1 at a clk edge clear every stage valid bit, out_valid=0, out=0, out_zero=0.
REQ-030 SHALL discard all in-flight requests on reset mid-operation; no result from before reset appears afterwards.
REQ-031 SHALL hold in_ready=1 during and after reset (out_valid=0).
REQ-032 SHALL not accept a request on a cycle where rst=1.

Verification
REQ-033 SHALL verify left logical: in=0x98000009, shiftby=4, shiftdir=1 -> out=0x80000090 after 5 cycles, out_zero=0.
REQ-034 SHALL verify right: in=0x90000009, shiftby=3 -> logical 0x12000001; shifta=1 -> 0xF2000001; in=0x10000009, shifta=1 -> 0x02000001.
REQ-035 SHALL verify rotate: in=0x98000009, rotate left 4 -> 0x80000099; in=0x90000009, rotate right 3 -> 0x32000001; shiftby=0 in any mode -> in unchanged.
REQ-036 SHALL verify back-to-back: 8 requests on consecutive cycles, out_ready=1 -> 8 results on consecutive cycles starting cycle 5, in order; in=0x00000001 left 0 vs right 1 -> out_zero=0 then 1.
REQ-037 SHALL verify backpressure: out_ready=0 for 10 cycles with pipeline full -> in_ready=0, out stable, no acceptance; releasing out_ready drains all results in order with none lost.
REQ-038 SHALL verify reset mid-flight: accept 3 requests, assert rst 1 cycle at cycle 2 -> out_valid stays 0 for the next SW+2 cycles, in_ready=1 afterwards.
